// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register file: 5:32 decode, pending-write exposure, flat register bus.
// Latency: request sampled at edge N, committed at edge N+1; pend_* is visible between those edges.
// Backpressure: none; one write is accepted every cycle and writes to ZERO_REG are dropped.
module regfile_write_port #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [32*WIDTH-1:0]   regs_flat,
    output logic                  pend_valid,
    output logic [4:0]            pend_addr,
    output logic [WIDTH-1:0]      pend_data,
    output logic [31:0]           wr_onehot,
    output logic [7:0]            wr_count
);

    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic             r_pend_valid;
    logic [4:0]       r_pend_addr;
    logic [WIDTH-1:0] r_pend_data;
    logic [7:0]       r_wr_count;
    logic             w_accept;
    logic [3:0]       w_grp;
    logic [31:0]      w_dec;

    assign w_accept = wr_en && (wr_addr != ZR);

    // Address/data hold their last accepted value so the read side sees stable pend_* when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= w_accept;
            if (w_accept) begin
                r_pend_addr <= wr_addr;
                r_pend_data <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count <= '0;
        end else if (r_pend_valid) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    always_comb begin
        w_grp = '0;
        w_grp[r_pend_addr[4:3]] = r_pend_valid;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec38
        assign w_dec[g*8 +: 8] = {8{w_grp[g]}} & (8'b1 << r_pend_addr[2:0]);
    end

    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs_flat[i*WIDTH +: WIDTH] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_reg <= '0;
                end else if (w_dec[i]) begin
                    r_reg <= r_pend_data;
                end
            end
            assign regs_flat[i*WIDTH +: WIDTH] = r_reg;
        end
    end

    assign pend_valid = r_pend_valid;
    assign pend_addr  = r_pend_addr;
    assign pend_data  = r_pend_data;
    assign wr_onehot  = w_dec;
    assign wr_count   = r_wr_count;

endmodule
